// File: rtl/rs_fifo_grace_tail.sv
// Consumer-end FIFO for a registered handshake chain. It drops if_full_n early, so words
// still in flight after the drop are absorbed. The read side is first-word-fall-through.
module rs_fifo_grace_tail #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GRACE      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - GRACE);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full_n;
    logic             r_overflow;

    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // A full FIFO still accepts a write when the same cycle frees a slot.
    always_comb begin
        w_pop  = if_read && (r_count != '0);
        w_push = if_write && ((r_count != FULL_CNT) || w_pop);
        w_drop = if_write && !w_push;
    end

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;

        if (w_push) begin
            w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full_n   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            // Registered from post-edge occupancy so upstream sees the GRACE headroom.
            r_full_n   <= (w_count_next < AFULL_CNT);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are only observable through valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= if_din;
        end
    end

    assign if_full_n  = r_full_n;
    assign if_empty_n = (r_count != '0);
    assign if_dout    = r_mem[r_rd_ptr];
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_rs_fifo_grace_tail.sv
// Bench for rs_fifo_grace_tail: directed tests on an 8-deep instance and a random-stream
// test on both the 8-deep and a 5-deep instance, checked against a queue model every cycle.
module tb_rs_fifo_grace_tail;

    localparam int DW  = 32;
    localparam int D_A = 8;
    localparam int G_A = 2;
    localparam int D_B = 5;
    localparam int G_B = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_write, a_read, b_write, b_read;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;
    logic          a_full_n, a_empty_n, a_ovf;
    logic          b_full_n, b_empty_n, b_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rs_fifo_grace_tail #(.DATA_WIDTH(DW), .DEPTH(D_A), .GRACE(G_A)) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_full_n  (a_full_n),
        .if_write   (a_write),
        .if_din     (a_din),
        .if_empty_n (a_empty_n),
        .if_read    (a_read),
        .if_dout    (a_dout),
        .overflow   (a_ovf)
    );

    rs_fifo_grace_tail #(.DATA_WIDTH(DW), .DEPTH(D_B), .GRACE(G_B)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_full_n  (b_full_n),
        .if_write   (b_write),
        .if_din     (b_din),
        .if_empty_n (b_empty_n),
        .if_read    (b_read),
        .if_dout    (b_dout),
        .overflow   (b_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue models: occupancy, ordering and flags straight from the behavioural rules.
    logic [DW-1:0] ma_q[$];
    logic [DW-1:0] mb_q[$];
    bit ma_full_n = 1'b0, ma_ovf = 1'b0;
    bit mb_full_n = 1'b0, mb_ovf = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model_a
        bit pop, push;
        if (!reset_n) begin
            ma_q.delete();
            ma_full_n = 1'b0;
            ma_ovf    = 1'b0;
        end else begin
            pop  = a_read && (ma_q.size() != 0);
            push = a_write && ((ma_q.size() != D_A) || pop);
            if (a_write && !push) ma_ovf = 1'b1;
            if (pop) void'(ma_q.pop_front());
            if (push) ma_q.push_back(a_din);
            ma_full_n = (ma_q.size() < D_A - G_A);
        end
    end

    always @(posedge clk or negedge reset_n) begin : model_b
        bit pop, push;
        if (!reset_n) begin
            mb_q.delete();
            mb_full_n = 1'b0;
            mb_ovf    = 1'b0;
        end else begin
            pop  = b_read && (mb_q.size() != 0);
            push = b_write && ((mb_q.size() != D_B) || pop);
            if (b_write && !push) mb_ovf = 1'b1;
            if (pop) void'(mb_q.pop_front());
            if (push) mb_q.push_back(b_din);
            mb_full_n = (mb_q.size() < D_B - G_B);
        end
    end

    always @(negedge clk) begin : compare
        check("a_empty_n", a_empty_n, ma_q.size() != 0);
        check("a_full_n", a_full_n, ma_full_n);
        check("a_overflow", a_ovf, ma_ovf);
        if (ma_q.size() != 0) check("a_dout", a_dout, ma_q[0]);
        check("b_empty_n", b_empty_n, mb_q.size() != 0);
        check("b_full_n", b_full_n, mb_full_n);
        check("b_overflow", b_ovf, mb_ovf);
        if (mb_q.size() != 0) check("b_dout", b_dout, mb_q[0]);
    end

    // Inputs change just after the falling edge, clear of both the compare and the DUT edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int a_sent, a_got, b_sent, b_got, cycles;
        bit a_seen, b_seen;

        a_write = 1'b0; a_read = 1'b0; a_din = '0;
        b_write = 1'b0; b_read = 1'b0; b_din = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;

        // T1: reset held with a write pending
        a_write = 1'b1; a_din = 32'hAA;
        repeat (3) step();
        check("t1_full_n_in_reset", a_full_n, 1'b0);
        check("t1_empty_n_in_reset", a_empty_n, 1'b0);
        check("t1_ovf_in_reset", a_ovf, 1'b0);
        a_write = 1'b0;
        reset_n = 1'b1;
        check("t1_full_n_before_edge", a_full_n, 1'b0);
        step();
        check("t1_full_n_after_edge", a_full_n, 1'b1);
        check("t1_empty_after_release", a_empty_n, 1'b0);

        // T2: fill; almost-full at 6 entries
        for (int i = 0; i < 6; i++) begin
            a_write = 1'b1; a_din = 32'(i);
            step();
            check("t2_full_n_fill", a_full_n, (i < 5) ? 1'b1 : 1'b0);
        end
        for (int i = 6; i < 8; i++) begin
            a_din = 32'(i);
            step();
        end
        a_write = 1'b0;
        check("t2_full_n_at_8", a_full_n, 1'b0);
        check("t2_ovf_at_8", a_ovf, 1'b0);
        check("t2_head", a_dout, 32'h0);

        // T3: drop at full
        a_write = 1'b1; a_din = 32'hDEAD;
        step();
        a_write = 1'b0;
        check("t3_ovf_set", a_ovf, 1'b1);
        check("t3_head_kept", a_dout, 32'h0);
        step();
        check("t3_ovf_sticky", a_ovf, 1'b1);

        // T4: simultaneous push/pop at full
        a_write = 1'b1; a_read = 1'b1; a_din = 32'h8;
        step();
        a_write = 1'b0; a_read = 1'b0;
        check("t4_head_advanced", a_dout, 32'h1);
        check("t4_full_n_still_low", a_full_n, 1'b0);
        a_read = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t4_drain_order", a_dout, 32'(k + 1));
            step();
        end
        check("t4_empty_after_drain", a_empty_n, 1'b0);
        check("t4_full_n_after_drain", a_full_n, 1'b1);
        step();
        check("t4_read_when_empty", a_empty_n, 1'b0);
        a_read = 1'b0;

        // T6: reset in the middle of a stream
        for (int i = 0; i < 4; i++) begin
            a_write = 1'b1; a_din = 32'h60 + 32'(i);
            step();
        end
        a_write = 1'b0;
        check("t6_empty_n_before", a_empty_n, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_empty_n_immediate", a_empty_n, 1'b0);
        check("t6_full_n_immediate", a_full_n, 1'b0);
        check("t6_ovf_cleared", a_ovf, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        check("t6_no_stale", a_empty_n, 1'b0);
        a_write = 1'b1; a_din = 32'h77;
        step();
        a_write = 1'b0;
        check("t6_fresh_head", a_dout, 32'h77);
        a_read = 1'b1;
        step();
        a_read = 1'b0;

        // T5: random streams; upstream reacts to if_full_n one cycle late
        a_sent = 0; a_got = 0; b_sent = 0; b_got = 0; cycles = 0;
        a_seen = a_full_n; b_seen = b_full_n;
        while ((a_got < 100 || b_got < 100) && cycles < 5000) begin
            a_write = a_seen && (a_sent < 100) && ($urandom_range(0, 3) != 0);
            a_din   = 32'h1000 + 32'(a_sent);
            a_read  = ($urandom_range(0, 2) != 0);
            if (a_read && a_empty_n) begin
                check("t5a_order", a_dout, 32'h1000 + 32'(a_got));
                a_got++;
            end
            if (a_write) a_sent++;
            b_write = b_seen && (b_sent < 100) && ($urandom_range(0, 3) != 0);
            b_din   = 32'h2000 + 32'(b_sent);
            b_read  = ($urandom_range(0, 2) != 0);
            if (b_read && b_empty_n) begin
                check("t5b_order", b_dout, 32'h2000 + 32'(b_got));
                b_got++;
            end
            if (b_write) b_sent++;
            a_seen = a_full_n;
            b_seen = b_full_n;
            step();
            cycles++;
        end
        a_write = 1'b0; a_read = 1'b0; b_write = 1'b0; b_read = 1'b0;
        check("t5a_received", 32'(a_got), 32'd100);
        check("t5b_received", 32'(b_got), 32'd100);
        step();
        check("t5a_no_overflow", a_ovf, 1'b0);
        check("t5b_no_overflow", b_ovf, 1'b0);
        check("t5a_empty", a_empty_n, 1'b0);
        check("t5b_empty", b_empty_n, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
